// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: program counter, saved fetch PC and instruction register
// for the multicycle RV32 core, plus the instruction-memory read handshake.
// Optional feature macro: FETCH_TIMEOUT_EN (abandon a fetch after TIMEOUT
// WAIT cycles without imem_ack). Default build waits indefinitely.
module instr_fetch_unit #(
  parameter int unsigned          XLEN      = 32,
  parameter logic [XLEN-1:0]      RESET_PC  = '0,
  parameter int unsigned          TIMEOUT   = 15,
  parameter logic [31:0]          NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic            ir_write,
  input  logic [XLEN-1:0] pc_next,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] old_pc,
  output logic [31:0]     instr,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic            busy,
  output logic            fetch_err
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state;

  // A zero timeout would abandon every fetch before memory could answer.
  if (TIMEOUT < 1) begin : g_timeout_range
    $error("instr_fetch_unit: TIMEOUT must be at least 1");
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT >= 16) ? $clog2(TIMEOUT + 1) : 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt;
`endif

  // Program counter: loads on every pc_write, independent of fetch state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (pc_write) begin
      pc <= pc_next;
    end
  end

  // Fetch FSM; imem_req/busy are registered copies of (state == WAIT) so they
  // drop asynchronously with reset and never depend on imem_ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      old_pc    <= RESET_PC;
      instr     <= NOP_INSTR;
      imem_req  <= 1'b0;
      busy      <= 1'b0;
      fetch_err <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ir_write) begin
            old_pc <= pc;
            if (pc[1:0] == 2'b00) begin
              state    <= WAIT;
              imem_req <= 1'b1;
              busy     <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
              cnt      <= '0;
`endif
            end else begin
              instr     <= NOP_INSTR;
              fetch_err <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (imem_ack) begin
            instr    <= imem_rdata;
            state    <= IDLE;
            imem_req <= 1'b0;
            busy     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
          // cnt counts completed ack-less WAIT cycles, so CNT_LAST marks the
          // TIMEOUT-th one; an ack in that cycle is handled above and wins.
          end else if (cnt == CNT_LAST) begin
            instr     <= NOP_INSTR;
            fetch_err <= 1'b1;
            state     <= IDLE;
            imem_req  <= 1'b0;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
`endif
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Read address and decode fields are pure wiring.
  always_comb begin
    imem_addr = old_pc;
    opcode    = instr[6:0];
    rd        = instr[11:7];
    funct3    = instr[14:12];
    rs1       = instr[19:15];
    rs2       = instr[24:20];
    funct7    = instr[31:25];
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write;
  logic        ir_write;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] pc;
  logic [31:0] old_pc;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic        busy;
  logic        fetch_err;

  int checks = 0;
  int failures = 0;

  instr_fetch_unit #(
    .XLEN(32),
    .RESET_PC(32'h0000_0000),
    .TIMEOUT(15),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .ir_write(ir_write),
    .pc_next(pc_next), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .pc(pc), .old_pc(old_pc),
    .instr(instr), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1),
    .rs2(rs2), .funct7(funct7), .busy(busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs are changed and outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    pc_next    = '0;
    imem_rdata = '0;
    imem_ack   = 1'b0;
  endtask

  task automatic set_pc(input logic [31:0] v);
    pc_write = 1'b1;
    pc_next  = v;
    tick();
    pc_write = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (old_pc !== 32'h0) begin failures++; $display("FAIL reset_old_pc got=%h exp=%h", old_pc, 32'h0); end
    checks++; if (instr !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", instr, NOP); end
    checks++; if ({imem_req, busy, fetch_err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {imem_req, busy, fetch_err}); end
  endtask

  task automatic test_zero_wait();
    int bcnt;
    set_pc(32'h100);
    ir_write = 1'b1; pc_write = 1'b1; pc_next = 32'h104;
    tick();
    ir_write = 1'b0; pc_write = 1'b0;
    checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL zw_addr got=%h exp=%h", imem_addr, 32'h100); end
    checks++; if (old_pc !== 32'h100) begin failures++; $display("FAIL zw_old_pc got=%h exp=%h", old_pc, 32'h100); end
    checks++; if (pc !== 32'h104) begin failures++; $display("FAIL zw_pc got=%h exp=%h", pc, 32'h104); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL zw_req got=%b exp=1", imem_req); end
    bcnt = 0;
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    while (busy === 1'b1 && bcnt < 10) begin
      bcnt++;
      tick();
      imem_ack = 1'b0; imem_rdata = '0;
    end
    checks++; if (bcnt !== 1) begin failures++; $display("FAIL zw_busy_cycles got=%0d exp=1", bcnt); end
    checks++; if (instr !== 32'h0050_0093) begin failures++; $display("FAIL zw_instr got=%h exp=%h", instr, 32'h0050_0093); end
    checks++; if (opcode !== 7'h13 || rd !== 5'd1) begin failures++; $display("FAIL zw_decode got=%h/%0d exp=13/1", opcode, rd); end
    checks++; if ({funct3, rs1, rs2, funct7} !== {3'd0, 5'd0, 5'd5, 7'd0}) begin failures++; $display("FAIL zw_fields got=%h exp=%h", {funct3, rs1, rs2, funct7}, {3'd0, 5'd0, 5'd5, 7'd0}); end
  endtask

  task automatic test_slow_mem();
    int bcnt;
    int rcnt;
    ir_write = 1'b1;
    tick();
    ir_write = 1'b0;
    bcnt = 0; rcnt = 0;
    while (busy === 1'b1 && bcnt < 10) begin
      bcnt++;
      if (imem_req === 1'b1) rcnt++;
      // second ir_write pulse plus a pc_write in WAIT cycle 2
      if (bcnt == 2) begin ir_write = 1'b1; pc_write = 1'b1; pc_next = 32'h200; end
      if (bcnt == 3) begin imem_ack = 1'b1; imem_rdata = 32'h00A0_0113; end
      tick();
      ir_write = 1'b0; pc_write = 1'b0; imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    end
    checks++; if (bcnt !== 3) begin failures++; $display("FAIL slow_busy_cycles got=%0d exp=3", bcnt); end
    checks++; if (rcnt !== 3) begin failures++; $display("FAIL slow_req_cycles got=%0d exp=3", rcnt); end
    checks++; if (instr !== 32'h00A0_0113) begin failures++; $display("FAIL slow_instr got=%h exp=%h", instr, 32'h00A0_0113); end
    checks++; if (old_pc !== 32'h104) begin failures++; $display("FAIL slow_old_pc got=%h exp=%h", old_pc, 32'h104); end
    checks++; if (pc !== 32'h200) begin failures++; $display("FAIL slow_pc got=%h exp=%h", pc, 32'h200); end
    // a stray ack while IDLE must not reload instr
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    checks++; if (instr !== 32'h00A0_0113 || busy !== 1'b0) begin failures++; $display("FAIL slow_idle_ack got=%h/%b exp=%h/0", instr, busy, 32'h00A0_0113); end
  endtask

  task automatic test_misaligned();
    set_pc(32'h102);
    ir_write = 1'b1;
    tick();
    ir_write = 1'b0;
    checks++; if (imem_req !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mis_req got=%b%b exp=00", imem_req, busy); end
    checks++; if (instr !== NOP) begin failures++; $display("FAIL mis_instr got=%h exp=%h", instr, NOP); end
    checks++; if (fetch_err !== 1'b1) begin failures++; $display("FAIL mis_err got=%b exp=1", fetch_err); end
    checks++; if (old_pc !== 32'h102) begin failures++; $display("FAIL mis_old_pc got=%h exp=%h", old_pc, 32'h102); end
    set_pc(32'h108);
    ir_write = 1'b1;
    tick();
    ir_write = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h0000_0533;
    tick();
    imem_ack = 1'b0;
    checks++; if (instr !== 32'h0000_0533) begin failures++; $display("FAIL mis_good_instr got=%h exp=%h", instr, 32'h0000_0533); end
    checks++; if (fetch_err !== 1'b1) begin failures++; $display("FAIL mis_err_sticky got=%b exp=1", fetch_err); end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    int bcnt;
    do_reset();
    ir_write = 1'b1;
    tick();
    ir_write = 1'b0;
    bcnt = 0;
    while (busy === 1'b1 && bcnt < 40) begin bcnt++; tick(); end
    checks++; if (bcnt !== 15) begin failures++; $display("FAIL to_cycles got=%0d exp=15", bcnt); end
    checks++; if (instr !== NOP || fetch_err !== 1'b1) begin failures++; $display("FAIL to_result got=%h/%b exp=%h/1", instr, fetch_err, NOP); end
    do_reset();
    ir_write = 1'b1;
    tick();
    ir_write = 1'b0;
    bcnt = 0;
    while (busy === 1'b1 && bcnt < 40) begin
      bcnt++;
      if (bcnt == 15) begin imem_ack = 1'b1; imem_rdata = 32'h1234_5013; end
      tick();
      imem_ack = 1'b0;
    end
    checks++; if (bcnt !== 15) begin failures++; $display("FAIL to_ack_cycles got=%0d exp=15", bcnt); end
    checks++; if (instr !== 32'h1234_5013 || fetch_err !== 1'b0) begin failures++; $display("FAIL to_ack_wins got=%h/%b exp=%h/0", instr, fetch_err, 32'h1234_5013); end
  endtask
`else
  task automatic test_long_wait();
    set_pc(32'h10);
    ir_write = 1'b1;
    tick();
    ir_write = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checks++; if (busy !== 1'b1 || imem_req !== 1'b1) begin failures++; $display("FAIL lw_hold got=%b%b exp=11", busy, imem_req); end
    imem_ack = 1'b1; imem_rdata = 32'h0040_0213;
    tick();
    imem_ack = 1'b0;
    checks++; if (instr !== 32'h0040_0213 || busy !== 1'b0) begin failures++; $display("FAIL lw_done got=%h/%b exp=%h/0", instr, busy, 32'h0040_0213); end
  endtask
`endif

  task automatic test_reset_mid_wait();
    set_pc(32'h40);
    ir_write = 1'b1;
    tick();
    ir_write = 1'b0;
    tick();
    // now in the 2nd WAIT cycle
    #2 rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rmw_async got=%b%b exp=00", imem_req, busy); end
    checks++; if (pc !== 32'h0 || old_pc !== 32'h0 || instr !== NOP || fetch_err !== 1'b0) begin failures++; $display("FAIL rmw_values got=%h/%h/%h/%b exp=0/0/%h/0", pc, old_pc, instr, fetch_err, NOP); end
    tick();
    rst = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'hCAFE_0093;
    tick();
    imem_ack = 1'b0;
    checks++; if (instr !== NOP || busy !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL rmw_late_ack got=%h/%b%b exp=%h/00", instr, busy, imem_req, NOP); end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_zero_wait();
    test_slow_mem();
    test_misaligned();
`ifdef FETCH_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
